// File: rtl/add_round_key_pkg.sv
// Shared AES width constants and column-slicing helpers for the AddRoundKey datapath.
// Columns are numbered from the MSB end: column 0 occupies STATE_W-1 down to STATE_W-WORD_W.
package add_round_key_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int NB      = 4;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [WORD_W-1:0]  word_t;

    function automatic int col_msb(input int c);
        return STATE_W - 1 - WORD_W * c;
    endfunction

endpackage

// File: rtl/add_round_key_ark_word.sv
// One 32-bit state column XORed bytewise with the matching round-key column.
// Pure combinational logic; the top level owns the output register.
module ark_word
    import add_round_key_pkg::*;
(
    input  logic [WORD_W-1:0] i_state,
    input  logic [WORD_W-1:0] i_key,
    output logic [WORD_W-1:0] o_word
);

    for (genvar b = 0; b < WORD_W / BYTE_W; b++) begin : g_byte
        assign o_word[WORD_W-1-BYTE_W*b -: BYTE_W] =
            i_state[WORD_W-1-BYTE_W*b -: BYTE_W] ^ i_key[WORD_W-1-BYTE_W*b -: BYTE_W];
    end

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey: out = in ^ key, built from four per-column ark_word slices.
// REG_OUT=1 adds one output register with async active-low clear; REG_OUT=0 is pure logic.
module add_round_key
    import add_round_key_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] in,
    input  logic [STATE_W-1:0] key,
    output logic [STATE_W-1:0] out
);

    logic [STATE_W-1:0] w_xor;

    for (genvar c = 0; c < NB; c++) begin : g_col
        ark_word u_ark_word (
            .i_state (in   [col_msb(c) -: WORD_W]),
            .i_key   (key  [col_msb(c) -: WORD_W]),
            .o_word  (w_xor[col_msb(c) -: WORD_W])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [STATE_W-1:0] r_out_p1;

        // Stage p1: registered result, cleared immediately by reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out_p1 <= '0;
            end else begin
                r_out_p1 <= w_xor;
            end
        end

        assign out = r_out_p1;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build
        logic w_unused_ctrl;
        assign w_unused_ctrl = clk ^ rst_n;
        assign out = w_xor;
    end

endmodule

// File: tb/tb_add_round_key.sv
// Randomized bench for add_round_key: registered and combinational builds side by side,
// compared against a bytewise reference model and FIPS-197 known-answer vectors.
module tb_add_round_key;

    logic         clk;
    logic         rst_n;
    logic [127:0] in;
    logic [127:0] key;
    logic [127:0] out_reg;
    logic [127:0] out_comb;

    int n_checks = 0;
    int n_errors = 0;

    add_round_key #(.REG_OUT(1'b1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .key   (key),
        .out   (out_reg)
    );

    add_round_key #(.REG_OUT(1'b0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .key   (key),
        .out   (out_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: split into 16 bytes (byte 0 at the MSB end), XOR pairwise, reassemble
    function automatic logic [127:0] ref_ark(input logic [127:0] s, input logic [127:0] k);
        logic [7:0]   sb [16];
        logic [7:0]   kb [16];
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = s[127-8*i -: 8];
            kb[i] = k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) begin
            r = (r << 8) | {120'h0, sb[i] ^ kb[i]};
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply a vector at the falling edge, then check both builds after the next rising edge
    task automatic apply(input string tag, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] exp);
        @(negedge clk);
        in  = a;
        key = b;
        #1;
        chk({tag, "_comb"}, out_comb, exp);
        @(posedge clk);
        #1;
        chk({tag, "_reg"}, out_reg, exp);
    endtask

    initial begin
        logic [127:0] a, b, prev;

        rst_n = 1'b0;
        in    = 128'h3243f6a8885a308d313198a2e0370734;
        key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        // Output held at zero through clock edges while reset is asserted
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold", out_reg, 128'h0);
        end
        chk("reset_comb", out_comb, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_after_reset", out_reg, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        apply("kat_round", 128'h5f72641557f5bc92f7be3b291db9f91a,
              128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 128'h89d810e8855ace682d1843d8cb128fe4);
        apply("kat_fips0", 128'h3243f6a8885a308d313198a2e0370734,
              128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        a = rand128();
        apply("in_eq_key", a, a, 128'h0);
        a = rand128();
        apply("key_zero", a, 128'h0, a);
        b = rand128();
        apply("in_ones", {128{1'b1}}, b, ~b);
        apply("one_byte", 128'h0, 128'h00000000_0000ff00_00000000_00000000,
              128'h00000000_0000ff00_00000000_00000000);

        // Mid-cycle input change must not reach the registered output before the edge
        a = rand128();
        b = rand128();
        apply("latency_setup", a, b, ref_ark(a, b));
        prev = ref_ark(a, b);
        @(negedge clk);
        a = rand128();
        b = rand128();
        in  = a;
        key = b;
        #1;
        chk("midcycle_hold", out_reg, prev);
        chk("midcycle_comb", out_comb, ref_ark(a, b));
        @(posedge clk);
        #1;
        chk("midcycle_update", out_reg, ref_ark(a, b));

        // Asynchronous clear between edges, then reload on the first edge after release
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_clear", out_reg, 128'h0);
        chk("async_comb", out_comb, ref_ark(a, b));
        @(posedge clk);
        #1;
        chk("clear_held", out_reg, 128'h0);
        @(negedge clk);
        a = rand128();
        b = rand128();
        in    = a;
        key   = b;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_after_reset", out_reg, ref_ark(a, b));

        for (int i = 0; i < 10000; i++) begin
            a = rand128();
            b = rand128();
            apply("random", a, b, ref_ark(a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
